// File: rtl/test_data_register_if.sv
// test_data_register_if: TAP/core-side bundle for test_data_register (serial TDI/TDO, Select/Bypass, Capture/Shift/UpdateDR strobes, ParallelIn/Out, optional ShiftCount/ShiftComplete under TDR_SHIFT_COUNT_EN)
interface test_data_register_if #(parameter int WIDTH = 8);
  logic             TDI;
  logic             Select;
  logic             Bypass;
  logic             CaptureDR;
  logic             ShiftDR;
  logic             UpdateDR;
  logic [WIDTH-1:0] ParallelIn;
  logic [WIDTH-1:0] ParallelOut;
  logic             TDO;
`ifdef TDR_SHIFT_COUNT_EN
  logic [$clog2(WIDTH+1)-1:0] ShiftCount;
  logic                       ShiftComplete;
`endif
  modport master (
    output TDI, Select, Bypass, CaptureDR, ShiftDR, UpdateDR, ParallelIn,
`ifdef TDR_SHIFT_COUNT_EN
    input ShiftCount, ShiftComplete,
`endif
    input ParallelOut, TDO
  );
  modport slave (
    input TDI, Select, Bypass, CaptureDR, ShiftDR, UpdateDR, ParallelIn,
`ifdef TDR_SHIFT_COUNT_EN
    output ShiftCount, ShiftComplete,
`endif
    output ParallelOut, TDO
  );
endinterface

// File: rtl/test_data_register.sv
// test_data_register: JTAG TDR with WIDTH-bit capture/shift stage, update stage and 1-bit bypass; ports ClockDR, Reset, bus (slave); macro TDR_SHIFT_COUNT_EN adds ShiftCount/ShiftComplete and gates UpdateDR on a full scan
module test_data_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              ClockDR,
  input logic              Reset,
  test_data_register_if.slave bus
);
  logic [WIDTH-1:0] shift_q, shift_d, upd_q, upd_d;
  logic             byp_q, byp_d;
  logic             complete;
  logic             cap, shf, upd;
`ifdef TDR_SHIFT_COUNT_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign complete          = cnt_q == CW'(WIDTH);
  assign bus.ShiftCount    = cnt_q;
  assign bus.ShiftComplete = complete;
`else
  assign complete = 1'b1;
`endif
  // strobe priority: capture over shift over update, all frozen when not selected
  assign cap = bus.Select & bus.CaptureDR;
  assign shf = bus.Select & ~bus.CaptureDR & bus.ShiftDR;
  assign upd = bus.Select & ~bus.CaptureDR & ~bus.ShiftDR & bus.UpdateDR & ~bus.Bypass & complete;
  always_comb begin
    shift_d = cap && !bus.Bypass ? bus.ParallelIn
            : shf && !bus.Bypass ? {bus.TDI, shift_q[WIDTH-1:1]}
            : shift_q;
    byp_d   = cap && bus.Bypass ? 1'b0
            : shf && bus.Bypass ? bus.TDI
            : byp_q;
    upd_d   = upd ? shift_q : upd_q;
`ifdef TDR_SHIFT_COUNT_EN
    cnt_d   = cap ? '0
            : shf && !bus.Bypass && !complete ? cnt_q + 1'b1
            : cnt_q;
`endif
  end
  always_ff @(posedge ClockDR) begin
    if (Reset) begin
      shift_q <= '0;
      byp_q   <= 1'b0;
      upd_q   <= RESET_VALUE;
`ifdef TDR_SHIFT_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      shift_q <= shift_d;
      byp_q   <= byp_d;
      upd_q   <= upd_d;
`ifdef TDR_SHIFT_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign bus.ParallelOut = upd_q;
  // TDO depends only on registered state and the mode inputs, never on TDI
  assign bus.TDO = bus.Select & (bus.Bypass ? byp_q : shift_q[0]);
endmodule

// File: doc/test_data_register.md
Name: test_data_register

Overview:
- Parametrised JTAG test data register; next generation of the single-bit bypass register.
- Three stages:
  - WIDTH-bit shift stage (TDI to TDO) with parallel capture.
  - Parallel update (hold) stage.
  - Run-time selectable 1-bit bypass mode.
- Sits between the TAP controller (drives CaptureDR/ShiftDR/UpdateDR) and core-side logic or boundary cells.
- Several instances share TDI; the TDO mux lives outside.

Parameters:
- WIDTH, 8, shift/update stage length in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into the update stage (ParallelOut) on reset.

Ports:
- ClockDR, input, 1, only clock; all state changes on the rising edge.
- Reset, input, 1, synchronous, active-high.
- TDI, input, 1, serial data in.
- Select, input, 1, register selected by the current instruction; 0 freezes all stages.
- Bypass, input, 1, 1 = behave as 1-bit bypass register; 0 = full WIDTH path.
- CaptureDR, input, 1, load ParallelIn into the shift stage.
- ShiftDR, input, 1, shift one bit toward the LSB per clock.
- UpdateDR, input, 1, copy the shift stage into the update stage.
- ParallelIn, input, WIDTH, capture source from core or pins.
- ParallelOut, output, WIDTH, update-stage value driven to core or pins.
- TDO, output, 1, serial data out.

Behaviour:
- Clock and reset:
  - One clock, ClockDR. Reset is synchronous and active-high, sampled on the ClockDR rising edge.
- Reset:
  - Shift stage = 0, bypass bit = 0, update stage = RESET_VALUE.
  - ParallelOut = RESET_VALUE, TDO = 0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-shift discards partial data; no update occurs.
- TDO:
  - Combinational from registered state only; no TDI-to-TDO combinational path.
  - TDO = bypass bit when Bypass = 1.
  - TDO = shift[0] when Bypass = 0 and Select = 1.
  - TDO = 0 when Select = 0.
- Select = 0:
  - Shift stage, bypass bit and update stage all hold; ParallelOut stable.
- Priority when Select = 1 and several strobes are high in one cycle: CaptureDR > ShiftDR > UpdateDR.
  - Only the highest-priority action executes.
  - Simultaneous strobes are a TAP protocol violation, but the behaviour is still fixed as above.
- Full mode (Bypass = 0):
  - CaptureDR: shift <= ParallelIn.
  - ShiftDR: shift <= {TDI, shift[WIDTH-1:1]}. LSB leaves first; the first TDI bit reaches shift[0] after WIDTH shifts.
  - UpdateDR: update <= shift. ParallelOut changes on the following cycle (1-clock latency from the UpdateDR edge).
  - Shifting never alters ParallelOut.
- Bypass mode (Bypass = 1):
  - CaptureDR: bypass bit <= 0 (IEEE 1149.1 bypass capture).
  - ShiftDR: bypass bit <= TDI, giving TDI-to-TDO latency of 1 clock.
  - UpdateDR: no effect; update stage holds.
  - Shift stage holds its contents while in bypass.
- Changing Bypass mid-operation:
  - Takes effect on the next edge; no stage is cleared.
  - TDO switches source combinationally in the same cycle.
- Shift-count boundaries:
  - More than WIDTH shifts: oldest bits fall off the LSB; the most recent WIDTH TDI bits remain.
  - Fewer than WIDTH shifts before UpdateDR: the partially shifted content is updated as is.

Optional Feature:
- Macro: TDR_SHIFT_COUNT_EN.
- With the macro defined:
  - Extra output ShiftCount, width $clog2(WIDTH+1).
  - Cleared by Reset and by CaptureDR.
  - Increments on each executed full-mode shift and saturates at WIDTH.
  - Extra output ShiftComplete = (ShiftCount == WIDTH), combinational from the counter.
  - UpdateDR is executed only when ShiftComplete = 1; otherwise it is ignored and the update stage holds. This guards against short scans.
- Without the macro:
  - Neither port exists; UpdateDR is unconditional as described in Behaviour.

Test Plan:
- Reset and TDO after reset: WIDTH=8, RESET_VALUE=8'hA5, assert Reset 1 cycle with strobes high -> ParallelOut = 8'hA5, TDO = 0, one cycle after Reset deasserts.
- Capture then shift out: ParallelIn = 8'h3C, CaptureDR 1 cycle, then ShiftDR 8 cycles with TDI = 0 -> TDO sequence 0,0,1,1,1,1,0,0 (LSB first); ParallelOut unchanged throughout.
- Shift in and update: shift in 8'h96 LSB first (8 cycles), UpdateDR 1 cycle -> ParallelOut = 8'h96 one cycle later; 9th shift before update -> ParallelOut = shifted value with the oldest bit dropped.
- Bypass: Bypass = 1, CaptureDR -> TDO = 0; ShiftDR with TDI pattern 1,0,1,1 -> TDO = 1,0,1,1 delayed by 1 clock; UpdateDR -> ParallelOut unchanged.
- Select = 0 freeze and priority:
  - Select = 0 with ShiftDR toggling -> TDO = 0, no state change.
  - Select = 1 with CaptureDR and ShiftDR high together -> shift = ParallelIn, no shift.
- With TDR_SHIFT_COUNT_EN: capture, 5 shifts, UpdateDR -> ShiftCount = 5, ParallelOut holds; 3 more shifts, UpdateDR -> ShiftComplete = 1, ParallelOut updated.
